// File: rtl/muldiv_unit.sv
// muldiv_unit
// Multi-cycle integer multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add on operand magnitudes and divide is restoring, one
// quotient bit per cycle; signed results are corrected on the final edge.
//
// Optional build macro: MULDIV_FAST_MULT_EN
//   defined   : MULT/MULTU use a single-cycle WIDTHxWIDTH multiplier
//               (results at T+1, busy for one cycle); divide is unchanged.
//   undefined : multiply is iterative with WIDTH-cycle latency.
//
// Ports
//   CLK          in   clock, rising edge active
//   RST          in   asynchronous active-low reset
//   start        in   issue request (ignored while busy)
//   op           in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
//   a, b         in   rs / rt operands
//   flush        in   cancels the in-flight operation, blocks a same-cycle start
//   busy         out  operation in progress
//   done         out  one-cycle pulse after HI/LO were written
//   div_by_zero  out  last completed divide had b == 0
//   hi, lo       out  HI / LO registers
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_r, state_next_s;
  logic [CW-1:0]      cnt_r;
  logic               is_div_r;
  logic               neg_q_r;     // negate quotient / product
  logic               neg_r_r;     // negate remainder
  logic               bzero_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   mag_a_r;
  logic [WIDTH-1:0]   mag_b_r;
  logic [2*WIDTH-1:0] acc_r;       // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               busy_r, done_r, dbz_r;

  logic               is_arith_s, is_move_s, is_signed_s;
  logic               accept_arith_s, accept_move_s, run_step_s, last_iter_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [WIDTH:0]     div_shift_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic [2*WIDTH-1:0] div_next_s;
  logic [2*WIDTH-1:0] iter_next_s;
  logic [2*WIDTH-1:0] mul_prod_s;
  logic [2*WIDTH-1:0] prod_signed_s;
  logic [WIDTH-1:0]   quo_s, rem_s;
  logic [WIDTH-1:0]   hi_res_s, lo_res_s;

  assign is_arith_s     = (op[2] == 1'b0);
  assign is_move_s      = (op == 3'd4) || (op == 3'd5);
  assign is_signed_s    = (op[0] == 1'b0);
  assign accept_arith_s = (state_r == IDLE) && start && !flush && is_arith_s;
  assign accept_move_s  = (state_r == IDLE) && start && !flush && is_move_s;
  assign run_step_s     = (state_r == RUN) && !flush;
  assign last_iter_s    = run_step_s && (cnt_r == CNT_ONE);

  // Operand magnitudes; MIN maps onto itself, which is the correct unsigned magnitude.
  assign mag_a_s = (is_signed_s && a[WIDTH-1]) ? -a : a;
  assign mag_b_s = (is_signed_s && b[WIDTH-1]) ? -b : b;

  // Restoring divide step: shift in the next dividend bit, subtract if it fits.
  assign div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
  assign div_ge_s    = (div_shift_s >= {1'b0, mag_b_r});
  assign div_diff_s  = div_shift_s[WIDTH-1:0] - mag_b_r;
  assign div_next_s  = div_ge_s ? {div_diff_s, acc_r[WIDTH-2:0], 1'b1}
                                : {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};

`ifdef MULDIV_FAST_MULT_EN
  assign mul_prod_s  = {{WIDTH{1'b0}}, mag_a_r} * {{WIDTH{1'b0}}, mag_b_r};
  assign iter_next_s = div_next_s;
`else
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  // Shift-add step: add multiplicand when the multiplier LSB is set, then shift right.
  assign mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                       (acc_r[0] ? {1'b0, mag_a_r} : {(WIDTH+1){1'b0}});
  assign mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
  assign mul_prod_s  = mul_next_s;
  assign iter_next_s = is_div_r ? div_next_s : mul_next_s;
`endif

  assign prod_signed_s = neg_q_r ? -mul_prod_s : mul_prod_s;
  assign quo_s         = neg_q_r ? -iter_next_s[WIDTH-1:0] : iter_next_s[WIDTH-1:0];
  assign rem_s         = neg_r_r ? -iter_next_s[2*WIDTH-1:WIDTH] : iter_next_s[2*WIDTH-1:WIDTH];

  // Final HI/LO values written on the last iteration edge.
  always_comb begin
    hi_res_s = prod_signed_s[2*WIDTH-1:WIDTH];
    lo_res_s = prod_signed_s[WIDTH-1:0];
    if (is_div_r) begin
      if (bzero_r) begin
        hi_res_s = a_r;
        lo_res_s = {WIDTH{1'b1}};
      end else begin
        hi_res_s = rem_s;
        lo_res_s = quo_s;
      end
    end else begin
      hi_res_s = prod_signed_s[2*WIDTH-1:WIDTH];
      lo_res_s = prod_signed_s[WIDTH-1:0];
    end
  end

  // Next-state logic; flush always returns to IDLE without a write.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_arith_s) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (flush || (cnt_r == CNT_ONE)) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RUN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath: operand capture, iteration, result write-back and status flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_r    <= CNT_ZERO;
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      bzero_r  <= 1'b0;
      a_r      <= {WIDTH{1'b0}};
      mag_a_r  <= {WIDTH{1'b0}};
      mag_b_r  <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dbz_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_next_s == RUN);
      if (accept_arith_s) begin
        is_div_r <= op[1];
        neg_q_r  <= is_signed_s && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r_r  <= is_signed_s && a[WIDTH-1];
        bzero_r  <= (b == {WIDTH{1'b0}});
        a_r      <= a;
        mag_a_r  <= mag_a_s;
        mag_b_r  <= mag_b_s;
        // Divide iterates on the dividend; multiply on the multiplier.
        acc_r    <= op[1] ? {{WIDTH{1'b0}}, mag_a_s} : {{WIDTH{1'b0}}, mag_b_s};
        dbz_r    <= 1'b0;
`ifdef MULDIV_FAST_MULT_EN
        cnt_r    <= op[1] ? CNT_FULL : CNT_ONE;
`else
        cnt_r    <= CNT_FULL;
`endif
      end else if (accept_move_s) begin
        if (op[0] == 1'b0) begin
          hi_r <= a;
        end else begin
          lo_r <= a;
        end
        done_r <= 1'b1;
        dbz_r  <= 1'b0;
      end else if (run_step_s) begin
        cnt_r <= cnt_r - CNT_ONE;
        acc_r <= iter_next_s;
        if (last_iter_s) begin
          hi_r   <= hi_res_s;
          lo_r   <= lo_res_s;
          done_r <= 1'b1;
          if (is_div_r) begin
            dbz_r <= bzero_r;
          end
        end
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign hi          = hi_r;
  assign lo          = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W;
`endif
  localparam int DIV_LAT = W;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        flush = 1'b0;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  logic        start16 = 1'b0;
  logic [2:0]  op16 = 3'd0;
  logic [15:0] a16 = 16'd0;
  logic [15:0] b16 = 16'd0;
  logic        flush16 = 1'b0;
  logic        busy16, done16, dbz16;
  logic [15:0] hi16, lo16;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  int   t0;
  int   n;

  muldiv_unit #(.WIDTH(32)) u_dut (
    .CLK(clk), .RST(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(16)) u_dut16 (
    .CLK(clk), .RST(rst_n), .start(start16), .op(op16), .a(a16), .b(b16), .flush(flush16),
    .busy(busy16), .done(done16), .div_by_zero(dbz16), .hi(hi16), .lo(lo16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("hi", hi, mon_e.hi);
        check_val("lo", lo, mon_e.lo);
        check_val("div_by_zero", dbz, mon_e.dbz);
        check_val("done_time", edge_cnt, mon_e.due);
        check_val("busy_at_done", busy, 64'd0);
      end
    end
  end

  // Called at a falling edge; start is sampled by the next rising edge.
  task automatic drive(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                       input bit push, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edbz, input int lat, input logic exp_busy);
    exp_t e;
    start = 1'b1; op = o; a = va; b = vb;
    if (push) begin
      e.hi = ehi; e.lo = elo; e.dbz = edbz; e.due = edge_cnt + 1 + lat;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    check_val("busy_after_start", busy, exp_busy);
  endtask

  task automatic drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_val("drain_timeout", sb_q.size(), 64'd0);
    sb_q.delete();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_val("rst_hi", hi, 64'd0);
    check_val("rst_lo", lo, 64'd0);
    check_val("rst_busy", busy, 64'd0);
    check_val("rst_done", done, 64'd0);
    check_val("rst_dbz", dbz, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    drive(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, MUL_LAT, 1'b1);
    drain();
    drive(3'd1, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'h0000_0006, 32'hFFFF_FFEB, 1'b0, MUL_LAT, 1'b1);
    drain();
    drive(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DIV_LAT, 1'b1);
    drain();
    drive(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, 1'b0, DIV_LAT, 1'b1);
    drain();
    drive(3'd3, 32'h1234_5678, 32'd0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, DIV_LAT, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    check_val("dbz_hold", dbz, 64'd1);

    // Long op in flight (5*6 or 30/1) with an ignored start at cycle 10.
    t0 = edge_cnt + 1;
    if (MUL_LAT > 10)
      drive(3'd1, 32'd5, 32'd6, 1'b1, 32'd0, 32'd30, 1'b0, MUL_LAT, 1'b1);
    else
      drive(3'd3, 32'd30, 32'd1, 1'b1, 32'd0, 32'd30, 1'b0, DIV_LAT, 1'b1);
    check_val("dbz_cleared", dbz, 64'd0);
    while (edge_cnt < t0 + 9) @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd99; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Same op flushed at cycle 10: no write, no done.
    t0 = edge_cnt + 1;
    if (MUL_LAT > 10)
      drive(3'd1, 32'd5, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, 0, 1'b1);
    else
      drive(3'd3, 32'd35, 32'd1, 1'b0, 32'd0, 32'd0, 1'b0, 0, 1'b1);
    while (edge_cnt < t0 + 9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_val("flush_busy", busy, 64'd0);
    check_val("flush_hi", hi, 64'd0);
    check_val("flush_lo", lo, 64'd30);
    repeat (40) @(negedge clk);
    check_val("flush_lo_later", lo, 64'd30);

    // flush and start in the same idle cycle: nothing accepted.
    start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check_val("flush_start_busy", busy, 64'd0);
    @(negedge clk);
    check_val("flush_start_hi", hi, 64'd0);

    // Reserved op: no effect.
    start = 1'b1; op = 3'd6; a = 32'h1111_1111;
    @(negedge clk);
    start = 1'b0;
    check_val("rsvd_busy", busy, 64'd0);
    repeat (3) @(negedge clk);
    check_val("rsvd_hi", hi, 64'd0);
    check_val("rsvd_lo", lo, 64'd30);

    // Back-to-back: second start issued in the done cycle of the first.
    drive(3'd1, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, 1'b0, MUL_LAT, 1'b1);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("b2b_done_seen", {63'd0, done}, 64'd1);
    drive(3'd2, 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, DIV_LAT, 1'b1);
    drain();

    // MTHI: write at T, done next cycle, never busy.
    drive(3'd4, 32'hCAFE_BABE, 32'd0, 1'b1, 32'hCAFE_BABE, 32'hFFFF_FFF2, 1'b0, 0, 1'b0);
    check_val("mthi_hi", hi, 64'hCAFE_BABE);
    drain();

    // Asynchronous reset in the middle of a divide.
    drive(3'd2, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, 0, 1'b1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_hi", hi, 64'd0);
    check_val("arst_lo", lo, 64'd0);
    check_val("arst_busy", busy, 64'd0);
    check_val("arst_done", done, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // WIDTH=16 DIVU 100/7: result after 16 edges.
    start16 = 1'b1; op16 = 3'd3; a16 = 16'd100; b16 = 16'd7;
    t0 = edge_cnt + 1;
    @(negedge clk);
    start16 = 1'b0;
    while (edge_cnt < t0 + 15) @(negedge clk);
    check_val("w16_busy_before", busy16, 64'd1);
    check_val("w16_done_before", done16, 64'd0);
    @(negedge clk);
    check_val("w16_done", done16, 64'd1);
    check_val("w16_lo", lo16, 64'd14);
    check_val("w16_hi", hi16, 64'd2);
    check_val("w16_busy_after", busy16, 64'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
